// File: rtl/adc_serial_arbiter.sv
// adc_serial_arbiter: round-robin sharing of the ADC 3-wire serial register
// port between NUM_REQ requesters. Each grant becomes one 32-bit write frame
// {12'h001, addr[3:0], data[15:0]} shifted MSB first.
// Ports:
//   Clock, Reset        system clock, asynchronous active-high reset
//   ReqValid/Addr/Data  per-requester write requests (slice i = requester i)
//   ReqReady            one-cycle accept pulse (address/data captured)
//   ReqDone             one-cycle pulse on the last gap cycle of the frame
//   Sclk/Sdata/Select   serial port (Sclk idles low, Select active low)
//   Busy                high whenever the engine is not idle
// Optional: define ADC_SERIAL_SHADOW_EN to add ShadowAddr/ShadowData and a
//   16x16 shadow copy of every completed register write.
module adc_serial_arbiter #(
  parameter int unsigned NUM_REQ    = 2,
  parameter int unsigned SCLK_DIV   = 4,
  parameter int unsigned GAP_CYCLES = 8
) (
  input  logic                    Clock,
  input  logic                    Reset,
  input  logic [NUM_REQ-1:0]      ReqValid,
  input  logic [4*NUM_REQ-1:0]    ReqAddr,
  input  logic [16*NUM_REQ-1:0]   ReqData,
  output logic [NUM_REQ-1:0]      ReqReady,
  output logic [NUM_REQ-1:0]      ReqDone,
  output logic                    Sclk,
  output logic                    Sdata,
  output logic                    Select,
`ifdef ADC_SERIAL_SHADOW_EN
  input  logic [3:0]              ShadowAddr,
  output logic [15:0]             ShadowData,
`endif
  output logic                    Busy
);

  localparam int unsigned PTR_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned CNT_MAX = (SCLK_DIV > GAP_CYCLES) ? SCLK_DIV : GAP_CYCLES;
  localparam int unsigned CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam int unsigned FRAME_W = 32;
  localparam int unsigned BIT_W   = 5;

  localparam logic [11:0]        HEADER   = 12'h001;
  localparam logic [CNT_W-1:0]   DIV_LAST = CNT_W'(SCLK_DIV - 1);
  localparam logic [CNT_W-1:0]   GAP_LAST = CNT_W'(GAP_CYCLES - 1);
  localparam logic [BIT_W-1:0]   BIT_LAST = BIT_W'(FRAME_W - 1);
  localparam logic [NUM_REQ-1:0] ONE_REQ  = NUM_REQ'(1);

  typedef enum logic [2:0] {S_IDLE, S_SETUP, S_SHIFT, S_HOLD, S_GAP} state_e;

  state_e               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [BIT_W-1:0]     bit_q, bit_d;
  logic                 phase_q, phase_d;   // 0: Sclk low half, 1: high half
  logic [FRAME_W-1:0]   sh_q, sh_d;
  logic [PTR_W-1:0]     ptr_q, ptr_d;
  logic [PTR_W-1:0]     gnt_q, gnt_d;
  logic [NUM_REQ-1:0]   ready_q, ready_d;
  logic [NUM_REQ-1:0]   done_q, done_d;
  logic                 sclk_q, sclk_d;
  logic                 sdata_q, sdata_d;
  logic                 select_q, select_d;
  logic                 busy_q, busy_d;

  logic                 found_c;
  logic [PTR_W-1:0]     pick_c;
  logic [3:0]           addr_c;
  logic [15:0]          data_c;

  // Round-robin scan starting at the pointer; first valid requester wins.
  always_comb begin
    logic [NUM_REQ-1:0]    vshift;
    logic [4*NUM_REQ-1:0]  ashift;
    logic [16*NUM_REQ-1:0] dshift;
    int unsigned           idx;
    found_c = 1'b0;
    pick_c  = '0;
    vshift  = '0;
    idx     = 0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      idx    = (32'(ptr_q) + i) % NUM_REQ;
      vshift = ReqValid >> idx;
      if (!found_c && vshift[0]) begin
        found_c = 1'b1;
        pick_c  = PTR_W'(idx);
      end
    end
    ashift = ReqAddr >> (32'(pick_c) * 32'd4);
    dshift = ReqData >> (32'(pick_c) * 32'd16);
    addr_c = ashift[3:0];
    data_c = dshift[15:0];
  end

  // Next state, frame sequencing and registered output values.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    phase_d = phase_q;
    sh_d    = sh_q;
    ptr_d   = ptr_q;
    gnt_d   = gnt_q;
    ready_d = '0;

    unique case (state_q)
      S_IDLE: begin
        if (found_c) begin
          state_d = S_SETUP;
          cnt_d   = '0;
          bit_d   = '0;
          phase_d = 1'b0;
          sh_d    = {HEADER, addr_c, data_c};
          ptr_d   = PTR_W'((32'(pick_c) + 32'd1) % NUM_REQ);
          gnt_d   = pick_c;
          ready_d = ONE_REQ << pick_c;
        end
      end
      S_SETUP: begin
        if (cnt_q == DIV_LAST) begin
          state_d = S_SHIFT;
          cnt_d   = '0;
          phase_d = 1'b0;
          bit_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_SHIFT: begin
        if (cnt_q == DIV_LAST) begin
          cnt_d = '0;
          if (!phase_q) begin
            phase_d = 1'b1;
          end else if (bit_q == BIT_LAST) begin
            state_d = S_HOLD;
            phase_d = 1'b0;
          end else begin
            // Next bit is presented only at the start of a low half.
            phase_d = 1'b0;
            bit_d   = bit_q + BIT_W'(1);
            sh_d    = {sh_q[FRAME_W-2:0], 1'b0};
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_HOLD: begin
        if (cnt_q == DIV_LAST) begin
          state_d = S_GAP;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_GAP: begin
        if (cnt_q == GAP_LAST) state_d = S_IDLE;
        else                   cnt_d   = cnt_q + CNT_W'(1);
      end
      default: state_d = S_IDLE;
    endcase

    done_d   = (state_d == S_GAP && cnt_d == GAP_LAST) ? (ONE_REQ << gnt_q) : '0;
    sclk_d   = (state_d == S_SHIFT) && phase_d;
    select_d = !(state_d inside {S_SETUP, S_SHIFT, S_HOLD});
    sdata_d  = (state_d inside {S_SETUP, S_SHIFT, S_HOLD}) ? sh_d[FRAME_W-1] : 1'b0;
    busy_d   = (state_d != S_IDLE);
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      bit_q    <= '0;
      phase_q  <= 1'b0;
      sh_q     <= '0;
      ptr_q    <= '0;
      gnt_q    <= '0;
      ready_q  <= '0;
      done_q   <= '0;
      sclk_q   <= 1'b0;
      sdata_q  <= 1'b0;
      select_q <= 1'b1;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      bit_q    <= bit_d;
      phase_q  <= phase_d;
      sh_q     <= sh_d;
      ptr_q    <= ptr_d;
      gnt_q    <= gnt_d;
      ready_q  <= ready_d;
      done_q   <= done_d;
      sclk_q   <= sclk_d;
      sdata_q  <= sdata_d;
      select_q <= select_d;
      busy_q   <= busy_d;
    end
  end

  assign ReqReady = ready_q;
  assign ReqDone  = done_q;
  assign Sclk     = sclk_q;
  assign Sdata    = sdata_q;
  assign Select   = select_q;
  assign Busy     = busy_q;

`ifdef ADC_SERIAL_SHADOW_EN
  logic [3:0]         wr_addr_q, wr_addr_d;
  logic [15:0]        wr_data_q, wr_data_d;
  logic [15:0][15:0]  shadow_q, shadow_d;

  // Capture the granted write; commit it when the frame completes.
  always_comb begin
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    shadow_d  = shadow_q;
    if (state_q == S_IDLE && found_c) begin
      wr_addr_d = addr_c;
      wr_data_d = data_c;
    end
    if (|done_q) shadow_d[wr_addr_q] = wr_data_q;
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      wr_addr_q <= '0;
      wr_data_q <= '0;
      shadow_q  <= '0;
    end else begin
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      shadow_q  <= shadow_d;
    end
  end

  assign ShadowData = shadow_q[ShadowAddr];
`endif

endmodule

// File: tb/tb_adc_serial_arbiter.sv
// tb_adc_serial_arbiter: directed self-checking bench for adc_serial_arbiter
// at default parameters (2 requesters, SCLK_DIV=4, GAP_CYCLES=8).
// Shadow checks are built when ADC_SERIAL_SHADOW_EN is defined.
module tb_adc_serial_arbiter;

  localparam int unsigned NUM_REQ = 2;

  logic                  Clock;
  logic                  Reset;
  logic [NUM_REQ-1:0]    ReqValid;
  logic [4*NUM_REQ-1:0]  ReqAddr;
  logic [16*NUM_REQ-1:0] ReqData;
  logic [NUM_REQ-1:0]    ReqReady;
  logic [NUM_REQ-1:0]    ReqDone;
  logic                  Sclk, Sdata, Select, Busy;
`ifdef ADC_SERIAL_SHADOW_EN
  logic [3:0]            ShadowAddr;
  logic [15:0]           ShadowData;
`endif

  adc_serial_arbiter #(.NUM_REQ(2), .SCLK_DIV(4), .GAP_CYCLES(8)) dut (
    .Clock(Clock), .Reset(Reset),
    .ReqValid(ReqValid), .ReqAddr(ReqAddr), .ReqData(ReqData),
    .ReqReady(ReqReady), .ReqDone(ReqDone),
    .Sclk(Sclk), .Sdata(Sdata), .Select(Select),
`ifdef ADC_SERIAL_SHADOW_EN
    .ShadowAddr(ShadowAddr), .ShadowData(ShadowData),
`endif
    .Busy(Busy)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  int passed = 0;
  int total  = 0;

  // Port monitor, sampled on the falling edge.
  int          cyc = 0;
  logic        sclk_p = 1'b0, sdata_p = 1'b0, sel_p = 1'b1;
  logic [31:0] rx = '0;
  int          rises = 0, sel_low = 0, sel_high = 0, last_low = 0, last_gap = 0;
  int          sdata_viol = 0, gcount = 0;
  int          glog_idx[32];
  int          glog_cyc[32];
  int          rdy0 = 0, rdy1 = 0, done0 = 0, done1 = 0;

  always @(negedge Clock) begin
    cyc++;
    if (ReqReady != 2'b00) begin
      rx = '0;
      rises = 0;
      if (gcount < 32) begin
        glog_idx[gcount] = ReqReady[1] ? 1 : 0;
        glog_cyc[gcount] = cyc;
      end
      gcount++;
    end
    if (ReqReady[0]) rdy0++;
    if (ReqReady[1]) rdy1++;
    if (ReqDone[0]) done0++;
    if (ReqDone[1]) done1++;
    if (Sclk && !sclk_p) begin
      rx = {rx[30:0], Sdata};
      rises++;
    end
    if (Sclk && sclk_p && Sdata !== sdata_p) sdata_viol++;
    if (!Select) begin
      if (sel_p) begin last_gap = sel_high; sel_low = 1; end
      else sel_low++;
    end else begin
      if (!sel_p) begin last_low = sel_low; sel_high = 1; end
      else sel_high++;
    end
    sclk_p = Sclk; sdata_p = Sdata; sel_p = Select;
  end

  typedef struct {
    int          idx;
    logic [3:0]  addr;
    logic [15:0] data;
    logic [31:0] frame;
  } vec_t;

  task automatic check(input string name, input logic signed [63:0] act,
                       input logic signed [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
  endtask

  task automatic tick();
    @(negedge Clock);
    #1;
  endtask

  task automatic set_req(input int idx, input logic [3:0] a, input logic [15:0] d, input logic v);
    if (idx == 0) begin ReqAddr[3:0] = a; ReqData[15:0]  = d; ReqValid[0] = v; end
    else          begin ReqAddr[7:4] = a; ReqData[31:16] = d; ReqValid[1] = v; end
  endtask

  // Ticks until ReqReady/ReqDone bit idx is seen; lat = ticks taken or -1.
  task automatic wait_bit(input bit is_done, input int idx, input int budget, output int lat);
    logic [NUM_REQ-1:0] sig;
    lat = -1;
    for (int n = 1; n <= budget; n++) begin
      tick();
      sig = is_done ? ReqDone : ReqReady;
      if (((sig >> idx) & 2'b01) != 2'b00) begin
        lat = n;
        break;
      end
    end
  endtask

  // One isolated write; address/data are scrambled right after acceptance.
  task automatic run_frame(input vec_t v, input string tag);
    int lat;
    set_req(v.idx, v.addr, v.data, 1'b1);
    wait_bit(1'b0, v.idx, 8, lat);
    check({tag, "_ready_lat"}, lat, 1);
    set_req(v.idx, ~v.addr, ~v.data, 1'b0);
    check({tag, "_busy"}, Busy, 1);
    wait_bit(1'b1, v.idx, 400, lat);
    check({tag, "_done_lat"}, lat, 271);
    check({tag, "_frame"}, rx, v.frame);
    check({tag, "_rises"}, rises, 32);
    check({tag, "_sel_low"}, last_low, 264);
    check({tag, "_busy_at_done"}, Busy, 1);
    tick();
    check({tag, "_idle"}, Busy, 0);
  endtask

  vec_t vecs[5];

  initial begin
    int lat, g0, got, early, r1, d0;

    vecs[0] = '{idx: 0, addr: 4'h1, data: 16'hB2FF, frame: 32'h0011B2FF};
    vecs[1] = '{idx: 1, addr: 4'hA, data: 16'h1234, frame: 32'h001A1234};
    vecs[2] = '{idx: 0, addr: 4'hF, data: 16'hFFFF, frame: 32'h001FFFFF};
    vecs[3] = '{idx: 1, addr: 4'h0, data: 16'h0000, frame: 32'h00100000};
    vecs[4] = '{idx: 0, addr: 4'h5, data: 16'h8001, frame: 32'h00158001};

    Reset = 1'b1; ReqValid = '0; ReqAddr = '0; ReqData = '0;
`ifdef ADC_SERIAL_SHADOW_EN
    ShadowAddr = 4'hD;
`endif
    #1;
    check("rst_sclk", Sclk, 0);
    check("rst_sdata", Sdata, 0);
    check("rst_select", Select, 1);
    check("rst_busy", Busy, 0);
    check("rst_ready", ReqReady, 0);
    check("rst_done", ReqDone, 0);
    tick(); tick();
    Reset = 1'b0;
    tick();

    // Contention: both requesters valid continuously, pointer starts at 0.
    ReqAddr = {4'h9, 4'h8}; ReqData = {16'hAAAA, 16'h5555}; ReqValid = 2'b11;
    g0 = gcount;
    for (int k = 0; k < 4; k++) begin
      got = 0;
      for (int n = 0; n < 600 && got == 0; n++) begin
        tick();
        if (gcount > g0 + k) got = 1;
      end
      check("cont_grant", (got != 0) ? glog_idx[g0 + k] : -1, k % 2);
      if (k > 0 && got != 0) begin
        check("cont_spacing", glog_cyc[g0 + k] - glog_cyc[g0 + k - 1], 273);
        check("cont_gap", last_gap, 9);
      end
    end
    ReqValid = '0;
    wait_bit(1'b1, 1, 400, lat);
    check("cont_last_done_lat", lat, 271);
    check("cont_last_frame", rx, 32'h0019AAAA);
    tick();

    // Table of isolated single writes.
    foreach (vecs[i]) run_frame(vecs[i], $sformatf("vec%0d", i));

    // Late arrival: req1 appears mid-frame, granted on the IDLE cycle after ReqDone.
    set_req(0, 4'h2, 16'h0102, 1'b1);
    wait_bit(1'b0, 0, 8, lat);
    ReqValid[0] = 1'b0;
    repeat (100) tick();
    set_req(1, 4'h3, 16'h0304, 1'b1);
    early = 0; lat = -1;
    for (int n = 1; n <= 300; n++) begin
      tick();
      if (ReqReady[1]) early = 1;
      if (ReqDone[0]) begin lat = n; break; end
    end
    check("late_no_early_grant", early, 0);
    check("late_req0_done_lat", lat, 171);
    wait_bit(1'b0, 1, 8, lat);
    check("late_grant_after_done", lat, 2);
    ReqValid[1] = 1'b0;
    wait_bit(1'b1, 1, 400, lat);
    check("late_req1_done_lat", lat, 271);
    check("late_req1_frame", rx, 32'h00130304);
    tick();

    // Withdrawn request: req1 valid for 3 cycles while busy, never granted.
    set_req(0, 4'h4, 16'h4444, 1'b1);
    wait_bit(1'b0, 0, 8, lat);
    ReqValid[0] = 1'b0;
    repeat (50) tick();
    r1 = rdy1;
    ReqValid[1] = 1'b1;
    repeat (3) tick();
    ReqValid[1] = 1'b0;
    wait_bit(1'b1, 0, 400, lat);
    check("wd_done_lat", lat, 218);
    repeat (20) tick();
    check("wd_no_grant", rdy1 - r1, 0);
    check("wd_idle", Busy, 0);

    // Reset at bit 10 of a frame.
    d0 = done0;
    set_req(0, 4'h7, 16'h55AA, 1'b1);
    wait_bit(1'b0, 0, 8, lat);
    ReqValid[0] = 1'b0;
    for (int n = 0; n < 400 && rises < 10; n++) tick();
    check("rst_mid_rises", rises, 10);
    check("rst_mid_sclk_before", Sclk, 1);
    #2 Reset = 1'b1;
    #1;
    check("rst_mid_select", Select, 1);
    check("rst_mid_sclk", Sclk, 0);
    check("rst_mid_busy", Busy, 0);
    tick(); tick();
    Reset = 1'b0;
    repeat (300) tick();
    check("rst_mid_no_done", done0 - d0, 0);
    run_frame(vecs[0], "post_rst");

`ifdef ADC_SERIAL_SHADOW_EN
    ShadowAddr = 4'hD;
    set_req(1, 4'hD, 16'h3FFF, 1'b1);
    wait_bit(1'b0, 1, 8, lat);
    ReqValid[1] = 1'b0;
    check("shadow_before", ShadowData, 0);
    wait_bit(1'b1, 1, 400, lat);
    tick();
    check("shadow_after", ShadowData, 16'h3FFF);
    Reset = 1'b1;
    #1;
    check("shadow_reset", ShadowData, 0);
    tick();
    Reset = 1'b0;
    tick();
`endif

    check("sdata_stable_while_sclk_high", sdata_viol, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/adc_serial_arbiter.md
Name: adc_serial_arbiter

Overview:
- Shares the ADC 3-wire serial register port (Sclk/Sdata/Select) between NUM_REQ requesters, e.g. the power/calibration FSM and the host command decoder.
- Round-robin arbitration; each granted request becomes one 32-bit ADC register write frame.
- Sits between the request sources and the tristate output pins, which are gated by OutToADCEnable elsewhere.

Parameters:
- NUM_REQ, 2, number of requesters (1..8).
- SCLK_DIV, 4, system clocks per Sclk half-period (>=2).
- GAP_CYCLES, 8, clocks Select stays high after a frame before the next frame may start (>=1).

Ports:
- Clock  in  1  system clock.
- Reset  in  1  asynchronous, active-high reset.
- ReqValid  in  NUM_REQ  request i pending; held until its ReqReady.
- ReqAddr  in  4*NUM_REQ  register address; slice i = [4i+3:4i].
- ReqData  in  16*NUM_REQ  register data; slice i = [16i+15:16i].
- ReqReady  out  NUM_REQ  one-cycle accept pulse; address/data captured this cycle.
- ReqDone  out  NUM_REQ  one-cycle pulse when requester i's frame is fully sent.
- Sclk  out  1  serial clock; idles low.
- Sdata  out  1  serial data, MSB first.
- Select  out  1  active-low frame select; idles high.
- Busy  out  1  high in every state except IDLE.

Behaviour:
- Reset values (asynchronous, immediate): Sclk=0, Sdata=0, Select=1, ReqReady=0, ReqDone=0, Busy=0, RR pointer=0, state=IDLE.
- Frame (32 bits, MSB first): 12'h001 header, then 4-bit address, then 16-bit data.
- IDLE:
  - Each cycle, scan ReqValid starting at the RR pointer; pick the first set bit.
  - Next clock: ReqReady[g] pulses for one cycle, frame is loaded, RR pointer = g+1 mod NUM_REQ, Select goes low, state -> SETUP.
- SETUP: SCLK_DIV cycles; Sclk=0; Sdata = bit31.
- SHIFT: 32 bit periods. Each period is SCLK_DIV cycles Sclk=0, then SCLK_DIV cycles Sclk=1.
  - Sdata changes only on the first cycle of a low phase, never while Sclk=1.
  - ADC samples on Sclk rising edge; exactly 32 rising edges per frame.
- HOLD: Sclk=0 for SCLK_DIV cycles; then Select=1.
- GAP: GAP_CYCLES cycles with Select=1.
  - ReqDone[g] pulses on the last GAP cycle.
  - State returns to IDLE on the following clock.
- Frame length from ReqReady to ReqDone: 1 + SCLK_DIV*(1+64+1) + GAP_CYCLES - 1 clocks; 272 clocks at defaults.
- Arbitration is evaluated only in IDLE; requests arriving mid-frame wait.
- A ReqValid that drops before its ReqReady is not granted and not remembered.
- Simultaneous requests: strict round robin. With two always-valid requesters, grants alternate 0,1,0,1.
- After ReqReady, the requester may change ReqAddr/ReqData or re-assert ReqValid freely; the captured frame is unaffected.
- Same requester re-requesting back-to-back: eligible at the next IDLE scan, but loses to any other valid requester after the pointer advance.
- Reset mid-frame: Select rises immediately and the partial frame is discarded (the ADC ignores frames shorter than 32 bits). No ReqDone is issued.
- Busy is high from the ReqReady cycle through the ReqDone cycle inclusive.

Optional Feature:
- Macro ADC_SERIAL_SHADOW_EN.
- Defined:
  - Adds ports ShadowAddr (in, 4) and ShadowData (out, 16).
  - 16x16 shadow register file, reset to 0. The entry for a frame's address is written with its data on that frame's ReqDone cycle.
  - ShadowData is a combinational read of entry ShadowAddr.
  - Reset clears all entries; aborted frames do not update the file.
- Undefined: ports and storage are absent; all other behaviour is identical.

Test Plan:
- Single write: req0 addr=4'h1 data=16'hB2FF, defaults ->
  - ReqReady[0] one cycle later.
  - Sampled bits on 32 Sclk rises = 32'h001_1_B2FF.
  - Select low for exactly 264 clocks.
  - ReqDone[0] 271 clocks after ReqReady.
- Contention: req0 and req1 both valid continuously ->
  - Grant order 0,1,0,1.
  - Select high ≥8 clocks between frames.
  - Sdata never changes while Sclk=1.
- Late arrival: req1 asserted mid-frame of req0 -> req1 granted exactly one cycle after req0's ReqDone (next IDLE cycle) and not before.
- Reset at bit 10 of a frame -> Select=1, Sclk=0 same cycle; no ReqDone; next request produces a full correct 32-bit frame.
- Withdrawn request: req1 pulses ReqValid for 3 cycles during busy, then drops -> no ReqReady[1], no frame.
- ADC_SERIAL_SHADOW_EN:
  - Write addr=4'hD data=16'h3FFF, then ShadowAddr=D -> ShadowData=16'h3FFF after ReqDone and 0 before.
  - Reset -> 0.
